// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared game-flow state encoding and HID keycode constants
// Rev 1.0  : initial release
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DYING = 3'd3,
    ST_CLEAR = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } game_state_e;

  localparam logic [7:0] KEY_START   = 8'd44;
  localparam logic [7:0] KEY_RESTART = 8'd40;
  localparam logic [7:0] KEY_PAUSE   = 8'd19;

endpackage
`default_nettype wire

// File: rtl/key_edge_detect.sv
`default_nettype none
// ============================================================================
// key_edge_detect : one-cycle press pulse when keycode changes to KEY_CODE
// Rev 1.0  : initial release
// ============================================================================
module key_edge_detect #(
  parameter logic [7:0] KEY_CODE = 8'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] keycode,
  output logic       press_o
);

  logic [7:0] prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 8'd0;
    end else begin
      prev_q <= keycode;
    end
  end

  // A held key keeps prev_q equal to keycode, so it never retriggers.
  assign press_o = (keycode == KEY_CODE) && (prev_q != keycode);

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// game_flow_ctrl : top-level game flow FSM (idle/play/dying/clear/win/lose)
// Optional pause state compiled in with macro GAME_PAUSE_EN.
// Rev 1.0  : initial release
// ============================================================================
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS   = 4,
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 90,
  parameter int CLEAR_FRAMES = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       player_hit,
  input  logic       burger_done,
  output logic       game_idle,
  output logic       game_play,
  output logic       game_pause,
  output logic       game_dying,
  output logic       game_clear,
  output logic       game_win,
  output logic       game_lose,
  output logic [((NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1)-1:0] level,
  output logic [3:0] lives,
  output logic       level_load,
  output logic       respawn
);

  localparam int LVL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int FRM_MAX = (DEATH_FRAMES > CLEAR_FRAMES) ? DEATH_FRAMES : CLEAR_FRAMES;
  localparam int CNT_W   = $clog2(FRM_MAX + 1);
  localparam logic [CNT_W-1:0] DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_FRAMES - 1);
  localparam logic [LVL_W-1:0] LEVEL_LAST  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [3:0]       LIVES_START = 4'(LIVES_INIT);

  game_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [3:0]       lives_q, lives_d;
  logic             load_q, load_d, resp_q, resp_d;
  logic             idle_q, play_q, dying_q, clear_q, win_q, lose_q;
  logic             start_press, restart_press;

  key_edge_detect #(.KEY_CODE(KEY_START)) u_key_start (
    .clock(clock), .reset(reset), .keycode(keycode), .press_o(start_press)
  );
  key_edge_detect #(.KEY_CODE(KEY_RESTART)) u_key_restart (
    .clock(clock), .reset(reset), .keycode(keycode), .press_o(restart_press)
  );

`ifdef GAME_PAUSE_EN
  logic pause_press, pause_q;

  key_edge_detect #(.KEY_CODE(KEY_PAUSE)) u_key_pause (
    .clock(clock), .reset(reset), .keycode(keycode), .press_o(pause_press)
  );

  always_ff @(posedge clock) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= (state_d == ST_PAUSE);
  end
  assign game_pause = pause_q;
`else
  assign game_pause = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    lives_d = lives_q;
    load_d  = 1'b0;
    resp_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d = ST_PLAY;
          level_d = '0;
          lives_d = LIVES_START;
          load_d  = 1'b1;
        end
      end
      ST_PLAY: begin
        // Holding the counter at zero here makes every DYING/CLEAR entry start fresh.
        cnt_d = '0;
        if (burger_done)     state_d = ST_CLEAR;
        else if (player_hit) state_d = ST_DYING;
`ifdef GAME_PAUSE_EN
        else if (pause_press) state_d = ST_PAUSE;
`endif
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (pause_press) state_d = ST_PLAY;
      end
`endif
      ST_DYING: begin
        if (frame_tick) begin
          if (cnt_q == DEATH_LAST) begin
            if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
            if (lives_q <= 4'd1) begin
              state_d = ST_LOSE;
            end else begin
              state_d = ST_PLAY;
              resp_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (frame_tick) begin
          if (cnt_q == CLEAR_LAST) begin
            if (level_q == LEVEL_LAST) begin
              state_d = ST_WIN;
            end else begin
              state_d = ST_PLAY;
              level_d = level_q + 1'b1;
              load_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (restart_press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flags are registered from the next state so they change with the transition edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= '0;
      lives_q <= 4'd0;
      load_q  <= 1'b0;
      resp_q  <= 1'b0;
      idle_q  <= 1'b1;
      play_q  <= 1'b0;
      dying_q <= 1'b0;
      clear_q <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      lives_q <= lives_d;
      load_q  <= load_d;
      resp_q  <= resp_d;
      idle_q  <= (state_d == ST_IDLE);
      play_q  <= (state_d == ST_PLAY);
      dying_q <= (state_d == ST_DYING);
      clear_q <= (state_d == ST_CLEAR);
      win_q   <= (state_d == ST_WIN);
      lose_q  <= (state_d == ST_LOSE);
    end
  end

  assign game_idle  = idle_q;
  assign game_play  = play_q;
  assign game_dying = dying_q;
  assign game_clear = clear_q;
  assign game_win   = win_q;
  assign game_lose  = lose_q;
  assign level      = level_q;
  assign lives      = lives_q;
  assign level_load = load_q;
  assign respawn    = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// tb_game_flow_ctrl : directed scenarios plus random play against a
// behavioural game-flow model; summary line at the end.
// Rev 1.0  : initial release
// ============================================================================
module tb_game_flow_ctrl;

  localparam int NL = 4, LI = 3, DF = 90, CF = 120;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clock = 1'b0, reset = 1'b1, frame_tick = 1'b0;
  logic       player_hit = 1'b0, burger_done = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic       game_idle, game_play, game_pause, game_dying, game_clear, game_win, game_lose;
  logic [1:0] level;
  logic [3:0] lives;
  logic       level_load, respawn;

  game_flow_ctrl #(.NUM_LEVELS(NL), .LIVES_INIT(LI), .DEATH_FRAMES(DF), .CLEAR_FRAMES(CF)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .keycode(keycode),
    .player_hit(player_hit), .burger_done(burger_done),
    .game_idle(game_idle), .game_play(game_play), .game_pause(game_pause),
    .game_dying(game_dying), .game_clear(game_clear), .game_win(game_win),
    .game_lose(game_lose), .level(level), .lives(lives),
    .level_load(level_load), .respawn(respawn)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int n_load = 0, n_resp = 0;
  bit checking = 1'b0;

  // Behavioural model: mode index 0..6 = idle, play, pause, dying, clear, win, lose.
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DYING = 3, M_CLEAR = 4, M_WIN = 5, M_LOSE = 6;
  int         m_mode = M_IDLE, m_level = 0, m_lives = 0, m_left = 0;
  bit         m_load = 1'b0, m_resp = 1'b0;
  logic [7:0] m_prev = 8'd0;
  bit         k_start, k_restart, k_pause;

  always @(posedge clock) begin
    k_start   = (keycode == 8'd44) && (m_prev != keycode);
    k_restart = (keycode == 8'd40) && (m_prev != keycode);
    k_pause   = (keycode == 8'd19) && (m_prev != keycode);
    m_load = 1'b0;
    m_resp = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_level = 0; m_lives = 0; m_left = 0; m_prev = 8'd0;
    end else begin
      m_prev = keycode;
      case (m_mode)
        M_IDLE: if (k_start) begin
          m_mode = M_PLAY; m_level = 0; m_lives = LI; m_load = 1'b1;
        end
        M_PLAY: begin
          if (burger_done) begin m_mode = M_CLEAR; m_left = CF; end
          else if (player_hit) begin m_mode = M_DYING; m_left = DF; end
          else if (PAUSE_EN && k_pause) m_mode = M_PAUSE;
        end
        M_PAUSE: if (k_pause) m_mode = M_PLAY;
        M_DYING: if (frame_tick) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_mode = M_LOSE;
            else begin m_mode = M_PLAY; m_resp = 1'b1; end
          end
        end
        M_CLEAR: if (frame_tick) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_level == NL - 1) m_mode = M_WIN;
            else begin m_level = m_level + 1; m_load = 1'b1; m_mode = M_PLAY; end
          end
        end
        default: if (k_restart) m_mode = M_IDLE;
      endcase
    end
  end

  logic [6:0] exp_flags, act_flags;
  always @(posedge clock) begin
    #1;
    if (level_load === 1'b1) n_load++;
    if (respawn === 1'b1) n_resp++;
    if (checking) begin
      exp_flags = 7'b1000000 >> m_mode;
      act_flags = {game_idle, game_play, game_pause, game_dying, game_clear, game_win, game_lose};
      total++;
      if (act_flags !== exp_flags || level !== 2'(m_level) || lives !== 4'(m_lives) ||
          level_load !== m_load || respawn !== m_resp) begin
        bad++;
        $display("FAIL model t=%0t flags=%b exp=%b level=%0d exp=%0d lives=%0d exp=%0d load=%b exp=%b resp=%b exp=%b",
                 $time, act_flags, exp_flags, level, m_level, lives, m_lives, level_load, m_load, respawn, m_resp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k; cyc(1); keycode = 8'd0; cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1); end
  endtask

  task automatic hit();
    player_hit = 1'b1; cyc(1); player_hit = 1'b0; cyc(1);
  endtask

  task automatic clear_level();
    burger_done = 1'b1; cyc(1); burger_done = 1'b0; cyc(1);
  endtask

  int l0, r0;

  initial begin
    reset = 1'b1;
    cyc(1);
    checking = 1'b1;
    chk("reset_idle", int'(game_idle), 1);
    chk("reset_lives", int'(lives), 0);
    chk("reset_level", int'(level), 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Held START: exactly one load.
    l0 = n_load;
    keycode = 8'd44;
    cyc(10);
    keycode = 8'd0;
    cyc(1);
    chk("start_loads", n_load - l0, 1);
    chk("start_play", int'(game_play), 1);
    chk("start_lives", int'(lives), 3);
    chk("start_level", int'(level), 0);

    // Lose all lives.
    hit();
    chk("hit_dying", int'(game_dying), 1);
    r0 = n_resp;
    ticks(DF);
    chk("death1_play", int'(game_play), 1);
    chk("death1_lives", int'(lives), 2);
    chk("death1_resp", n_resp - r0, 1);
    hit(); ticks(DF);
    chk("death2_lives", int'(lives), 1);
    hit();
    r0 = n_resp;
    ticks(DF);
    chk("death3_lose", int'(game_lose), 1);
    chk("death3_lives", int'(lives), 0);
    chk("death3_noresp", n_resp - r0, 0);
    press(8'd40);
    chk("restart_idle", int'(game_idle), 1);
    chk("restart_lives_held", int'(lives), 0);

    // Simultaneous hit and burger: clear wins.
    press(8'd44);
    player_hit = 1'b1; burger_done = 1'b1; cyc(1);
    player_hit = 1'b0; burger_done = 1'b0; cyc(1);
    chk("both_clear", int'(game_clear), 1);
    chk("both_lives", int'(lives), 3);

    // Progress through all levels.
    for (int i = 1; i <= 3; i++) begin
      l0 = n_load;
      ticks(CF);
      chk("clear_level", int'(level), i);
      chk("clear_load", n_load - l0, 1);
      chk("clear_play", int'(game_play), 1);
      clear_level();
    end
    l0 = n_load;
    ticks(CF);
    chk("win_flag", int'(game_win), 1);
    chk("win_level", int'(level), 3);
    chk("win_noload", n_load - l0, 0);
    press(8'd40);
    chk("win_idle", int'(game_idle), 1);
    chk("win_level_held", int'(level), 3);

    // Reset mid-DYING.
    press(8'd44);
    hit();
    ticks(45);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("midreset_idle", int'(game_idle), 1);
    chk("midreset_lives", int'(lives), 0);
    chk("midreset_level", int'(level), 0);
    cyc(1);
    press(8'd44);
    hit();
    ticks(DF - 1);
    chk("fresh_still_dying", int'(game_dying), 1);
    ticks(1);
    chk("fresh_play", int'(game_play), 1);
    chk("fresh_lives", int'(lives), 2);

`ifdef GAME_PAUSE_EN
    press(8'd19);
    chk("pause_on", int'(game_pause), 1);
    player_hit = 1'b1;
    ticks(200);
    player_hit = 1'b0;
    cyc(1);
    chk("pause_held", int'(game_pause), 1);
    chk("pause_lives", int'(lives), 2);
    l0 = n_load; r0 = n_resp;
    press(8'd19);
    chk("unpause_play", int'(game_play), 1);
    chk("unpause_lives", int'(lives), 2);
    chk("unpause_pulses", (n_load - l0) + (n_resp - r0), 0);
`else
    press(8'd19);
    chk("nopause_play", int'(game_play), 1);
    chk("nopause_flag", int'(game_pause), 0);
`endif

    // Random play against the model.
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0, 1: keycode = 8'd0;
          2:    keycode = 8'd44;
          3:    keycode = 8'd40;
          4:    keycode = 8'd19;
          default: keycode = 8'($urandom);
        endcase
      end
      frame_tick  = ($urandom_range(0, 2) == 0);
      player_hit  = ($urandom_range(0, 39) == 0);
      burger_done = ($urandom_range(0, 59) == 0);
      reset       = ($urandom_range(0, 2999) == 0);
      cyc(1);
    end
    reset = 1'b0; frame_tick = 1'b0; player_hit = 1'b0; burger_done = 1'b0; keycode = 8'd0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 4: levels per game, minimum 1.
REQ-002 SHALL have parameter LIVES_INIT, default 3: lives at game start, range 1..15.
REQ-003 SHALL have parameter DEATH_FRAMES, default 90: frame ticks spent in DYING, minimum 1.
REQ-004 SHALL have parameter CLEAR_FRAMES, default 120: frame ticks spent in LEVEL_CLEAR, minimum 1.
REQ-005 SHALL have ports clock, reset, frame_tick and keycode as inputs:
- clock  in  1: system clock.
- reset  in  1: reset, synchronous, active-high; clock is clock.
- frame_tick  in  1: one-cycle pulse per video frame.
- keycode  in  8: current USB HID keycode; 0 = none.
REQ-006 SHALL have ports player_hit and burger_done as inputs:
- player_hit  in  1: level-sensitive; player collided with an enemy.
- burger_done  in  1: level-sensitive; all burgers of the current level are complete.
REQ-007 SHALL have state-flag outputs, each 1 bit:
- game_idle, game_play, game_pause, game_dying, game_clear, game_win, game_lose.
- Exactly one is high at any time.
REQ-008 SHALL have counter outputs:
- level  out  $clog2(NUM_LEVELS) (min 1): current level, 0-based.
- lives  out  4: remaining lives.
REQ-009 SHALL have pulse outputs, each 1 bit:
- level_load: one-cycle pulse; reload level map and entities.
- respawn: one-cycle pulse; reposition player and enemies.

Function
REQ-010 SHALL implement states IDLE, PLAY, PAUSE, DYING, CLEAR, WIN and LOSE.
REQ-011 SHALL treat a key as pressed only on the cycle keycode changes from a different value to the key's code (rising match):
- START = 8'd44 (space), RESTART = 8'd40 (enter), PAUSE = 8'd19 (P).
- A held key SHALL NOT retrigger.
REQ-012 SHALL leave IDLE on START:
- Go to PLAY.
- Set level = 0 and lives = LIVES_INIT.
- Pulse level_load in the transition cycle.
REQ-013 SHALL, in PLAY, apply these exits in priority order:
- burger_done -> CLEAR.
- else player_hit -> DYING.
- else PAUSE key -> PAUSE.
REQ-014 SHALL run a frame counter in DYING:
- Counter clears on entry and increments on frame_tick.
- At the DEATH_FRAMES-th tick, lives decrements by 1.
- Then go to LOSE if the new value is 0; otherwise go to PLAY and pulse respawn.
REQ-015 SHALL run the same counter in CLEAR:
- At the CLEAR_FRAMES-th tick, go to WIN if level == NUM_LEVELS-1.
- Otherwise increment level, pulse level_load and go to PLAY.
REQ-016 SHALL, from WIN or LOSE, go to IDLE on RESTART.
- level and lives hold their values until the next START.
REQ-017 SHALL ignore player_hit and burger_done outside PLAY.
REQ-018 SHALL ignore keys in DYING and CLEAR.
REQ-019 SHALL register all outputs: a transition taken at edge N is visible on the flags after edge N.
REQ-020 SHALL NOT wrap or underflow lives; it is a don't-care when lives is already 0 in DYING, which is unreachable.
REQ-021 SHALL count a frame_tick coincident with state entry as tick 1 only if it arrives on or after the first cycle in the new state.

Reset
REQ-022 SHALL, on reset, go to IDLE regardless of current state, including mid-DYING and mid-CLEAR.
REQ-023 SHALL, on reset, set game_idle = 1, all other flags = 0, level = 0, lives = 0, level_load = respawn = 0.
- Frame counter and key-edge history SHALL also clear.

Configuration
REQ-024 SHALL compile pause support only when macro GAME_PAUSE_EN is defined.
REQ-025 SHALL, with GAME_PAUSE_EN, handle PAUSE as follows:
- PAUSE key in PLAY -> PAUSE.
- PAUSE key in PAUSE -> PLAY, with no respawn or level_load.
- In PAUSE, the frame counter freezes and player_hit / burger_done are ignored.
REQ-026 SHALL, without GAME_PAUSE_EN, have no PAUSE state.
- game_pause is tied to 0 and the PAUSE key is ignored.

Structure
REQ-027 SHALL take the state enum typedef and the keycode constants (KEY_START, KEY_RESTART, KEY_PAUSE) from shared package game_pkg.
REQ-028 SHALL instantiate sub-module key_edge_detect once per key to produce the one-cycle press pulses.
- Inputs: clock, reset, keycode. Parameter: the key code.

Verification
REQ-029 SHALL verify: hold keycode=44 for 10 cycles in IDLE -> one level_load pulse, game_play=1, lives=3, level=0, no retrigger.
REQ-030 SHALL verify: player_hit pulse in PLAY with lives=1 -> game_dying; after 90 frame_ticks -> lives=0, game_lose=1, no respawn; keycode=40 -> game_idle.
REQ-031 SHALL verify: player_hit and burger_done in the same PLAY cycle -> game_clear, lives unchanged.
REQ-032 SHALL verify: four clears with NUM_LEVELS=4 -> level 0,1,2,3 with a level_load pulse at each; the fourth CLEAR expiry -> game_win, level=3.
REQ-033 SHALL verify: reset asserted at frame 45 of DYING -> next cycle game_idle=1, lives=0, counter restarts cleanly on the next game.
REQ-034 SHALL verify: with GAME_PAUSE_EN, keycode=19 in PLAY, then 200 frame_ticks and a player_hit -> state stays PAUSE; second press -> PLAY, lives unchanged; without the macro, keycode=19 -> state stays PLAY.
